conv_result_collector: RTL and testbench
========================================

Name: conv_result_collector

Overview:
- Receive end of the conv output stream (dout/ovalid/done), and the RTL replacement for the bench-side result capture.
- Captures one convolution frame into internal RAM: 24x24 = 576 results in layer-1 mode, 8x8 = 64 in layer-2 mode.
- Replays the captured frame in raster order over a valid/ready stream to the next stage (pooling / binarize / host dump).

Parameters:
- DATA_W, 32, conv result width (signed two's complement).
- N_L1, 576, results per frame when state=0.
- N_L2, 64, results per frame when state=1.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= N_L1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- state  in  1  layer select (0: N_L1, 1: N_L2); sampled at frame start.
- din  in  DATA_W  conv result (signed).
- ivalid  in  1  din valid (conv ovalid).
- idone  in  1  final result of frame (conv done); only meaningful with ivalid=1.
- dout  out  DATA_W  replayed result.
- ovalid  out  1  dout valid.
- oready  in  1  downstream accept.
- olast  out  1  marks the last replayed word.
- busy  out  1  high in FILL or DRAIN.
- len_err  out  1  sticky: frame length mismatch.
- ovf_err  out  1  sticky: input dropped.

Behaviour:
- Reset values: dout=0, ovalid=0, olast=0, busy=0, len_err=0, ovf_err=0. FSM=IDLE, pointers=0. RAM contents are not reset.
- Reset mid-operation: asserting rst in any state returns to the reset values on the same edge. A partial frame is discarded.
- FSM states: IDLE, FILL, DRAIN.
- IDLE: on ivalid=1:
  - latch n_exp = state ? N_L2 : N_L1;
  - write din to addr 0;
  - wr_ptr=1;
  - go to FILL, or directly to DRAIN if idone=1 in the same cycle.
- FILL:
  - Each ivalid=1 with wr_ptr < n_exp writes din at wr_ptr and increments wr_ptr.
  - ivalid=1 with wr_ptr == n_exp: the word is dropped and ovf_err=1.
  - ivalid=1 with idone=1: writes (if room), sets n_got = words stored, goes to DRAIN.
  - If n_got != n_exp at that point, len_err=1. The drain still proceeds with n_got words.
- DRAIN:
  - Synchronous-read RAM, 1-cycle read latency. Prefetch so ovalid rises 2 cycles after the idone cycle.
  - Word k is presented with olast = (k == n_got-1).
  - A transfer occurs on ovalid & oready. dout/ovalid/olast hold while oready=0.
  - Full throughput: one word per cycle while oready=1. Use a 2-entry output skid so a read is never lost.
  - After the olast transfer, the next cycle has ovalid=0 and FSM=IDLE.
  - ivalid=1 during DRAIN: the word is dropped and ovf_err=1.
- Same-cycle events: a final olast transfer and a new ivalid in the same cycle is treated as a drop (state is still DRAIN).
- Data is passed unmodified: dout equals din bit-exact, signed.
- busy = (FSM != IDLE).
- Sticky errors clear only on rst.

Optional Feature:
- Macro: CONV_BIN_EN.
- Defined: each word is binarized on write. Stored value = {(DATA_W-1)'b0, ~din[DATA_W-1]}, i.e. 1 when din >= 0 and 0 when negative, feeding the binary next layer.
- Undefined: full DATA_W signed value stored and replayed.
- Latency and handshake are identical either way.

Test Plan:
- state=0; feed 576 words din=i-288 (i=0..575), idone on i=575; oready=1 → 576 outputs equal to -288..287 in order; olast only on the 576th; len_err=0, ovf_err=0; busy falls after the last transfer.
- state=1; feed 64 words din=i*3, gaps of 2 idle cycles between words → 64 outputs 0..189 step 3; olast on word 63.
- Drain with oready toggling 1,0,0,1 repeating → no duplicated or missing words; dout stable while oready=0.
- state=1; idone on word 40 → len_err=1; exactly 40 words replayed; olast on word 39.
- state=1; 70 words, idone on word 70 → words 65-70 dropped, ovf_err=1; first 64 replayed.
- Assert rst after 10 words of a 576-word drain → ovalid=0 and busy=0 immediately. A following 64-word frame replays correctly.
- CONV_BIN_EN defined; din = -5, 0, 7 → dout = 0, 1, 1.

Source files
------------

// File: rtl/conv_result_collector.sv
// Captures one conv output frame into RAM and replays it over a valid/ready stream.
// Optional CONV_BIN_EN: store 1 for din >= 0 and 0 for negative din instead of the full value.
module conv_result_collector #(
    parameter int DATA_W = 32,
    parameter int N_L1   = 576,
    parameter int N_L2   = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              state,
    input  logic [DATA_W-1:0] din,
    input  logic              ivalid,
    input  logic              idone,
    output logic [DATA_W-1:0] dout,
    output logic              ovalid,
    input  logic              oready,
    output logic              olast,
    output logic              busy,
    output logic              len_err,
    output logic              ovf_err
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] N1C = CW'(N_L1);
    localparam logic [CW-1:0] N2C = CW'(N_L2);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     n_exp_q, n_exp_d;
    logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_last_q, rd_last_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic              ent0_last_q, ent0_last_d, ent1_last_q, ent1_last_d;
    logic              len_err_q, len_err_d;
    logic              ovf_err_q, ovf_err_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic              we, re, pop;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        occ;

    always_comb begin
`ifdef CONV_BIN_EN
        wdata = {{(DATA_W-1){1'b0}}, ~din[DATA_W-1]};
`else
        wdata = din;
`endif
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign pop = (cnt_q != 2'd0) && oready;
    // Words already held plus the one in flight from the RAM, net of this cycle's pop.
    assign occ = {1'b0, cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};

    always_comb begin
        fsm_d       = fsm_q;
        wr_ptr_d    = wr_ptr_q;
        n_exp_d     = n_exp_q;
        rd_ptr_d    = rd_ptr_q;
        rd_pend_d   = 1'b0;
        rd_last_d   = rd_last_q;
        cnt_d       = cnt_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        ent0_last_d = ent0_last_q;
        ent1_last_d = ent1_last_q;
        len_err_d   = len_err_q;
        ovf_err_d   = ovf_err_q;
        we          = 1'b0;
        re          = 1'b0;
        waddr       = wr_ptr_q[ADDR_W-1:0];
        raddr       = rd_ptr_q[ADDR_W-1:0];

        if (pop && rd_pend_q) begin
            if (cnt_q == 2'd2) begin
                ent0_d      = ent1_q;
                ent0_last_d = ent1_last_q;
                ent1_d      = rdata_q;
                ent1_last_d = rd_last_q;
            end else begin
                ent0_d      = rdata_q;
                ent0_last_d = rd_last_q;
            end
        end else if (pop) begin
            ent0_d      = ent1_q;
            ent0_last_d = ent1_last_q;
            cnt_d       = cnt_q - 2'd1;
        end else if (rd_pend_q) begin
            if (cnt_q == 2'd0) begin
                ent0_d      = rdata_q;
                ent0_last_d = rd_last_q;
            end else begin
                ent1_d      = rdata_q;
                ent1_last_d = rd_last_q;
            end
            cnt_d = cnt_q + 2'd1;
        end

        case (fsm_q)
            IDLE: begin
                if (ivalid) begin
                    n_exp_d  = state ? N2C : N1C;
                    we       = 1'b1;
                    waddr    = '0;
                    wr_ptr_d = CW'(1);
                    if (idone) begin
                        fsm_d = DRAIN;
                        if (n_exp_d != CW'(1)) len_err_d = 1'b1;
                    end else begin
                        fsm_d = FILL;
                    end
                end
            end
            FILL: begin
                if (ivalid) begin
                    if (wr_ptr_q < n_exp_q) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + CW'(1);
                    end else begin
                        ovf_err_d = 1'b1;
                    end
                    if (idone) begin
                        fsm_d = DRAIN;
                        if (wr_ptr_d != n_exp_q) len_err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ivalid) ovf_err_d = 1'b1;
                if ((rd_ptr_q < wr_ptr_q) && (occ < 3'd2)) begin
                    re        = 1'b1;
                    rd_pend_d = 1'b1;
                    rd_last_d = (rd_ptr_q == wr_ptr_q - CW'(1));
                    rd_ptr_d  = rd_ptr_q + CW'(1);
                end
                if (pop && ent0_last_q) begin
                    fsm_d     = IDLE;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    rd_pend_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            wr_ptr_q    <= '0;
            n_exp_q     <= '0;
            rd_ptr_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            cnt_q       <= '0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            ent0_last_q <= 1'b0;
            ent1_last_q <= 1'b0;
            len_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            wr_ptr_q    <= wr_ptr_d;
            n_exp_q     <= n_exp_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            cnt_q       <= cnt_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            ent0_last_q <= ent0_last_d;
            ent1_last_q <= ent1_last_d;
            len_err_q   <= len_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign dout    = ent0_q;
    assign ovalid  = (cnt_q != 2'd0);
    assign olast   = (cnt_q != 2'd0) && ent0_last_q;
    assign busy    = (fsm_q != IDLE);
    assign len_err = len_err_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed and randomized frames for conv_result_collector, checked against a queue-based frame model.
module tb_conv_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        state;
    logic [31:0] din;
    logic        ivalid;
    logic        idone;
    logic [31:0] dout;
    logic        ovalid;
    logic        oready;
    logic        olast;
    logic        busy;
    logic        len_err;
    logic        ovf_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] fdata [0:1023];
    logic [31:0] exp_q [$];
    logic        len_exp = 1'b0;
    logic        ovf_exp = 1'b0;

    conv_result_collector #(
        .DATA_W(32),
        .N_L1  (576),
        .N_L2  (64),
        .ADDR_W(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .din    (din),
        .ivalid (ivalid),
        .idone  (idone),
        .dout   (dout),
        .ovalid (ovalid),
        .oready (oready),
        .olast  (olast),
        .busy   (busy),
        .len_err(len_err),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] d);
`ifdef CONV_BIN_EN
        return ($signed(d) >= 0) ? 32'd1 : 32'd0;
`else
        return d;
`endif
    endfunction

    task automatic feed(input logic st, input int n, input int gap);
        int n_exp;
        int stored;
        state = st;
        for (int i = 0; i < n; i++) begin
            ivalid = 1'b1;
            din    = fdata[i];
            idone  = (i == n - 1);
            @(posedge clk);
            #1;
            ivalid = 1'b0;
            idone  = 1'b0;
            if (i == 0) chk("busy_fill", 32'(busy), 32'd1);
            if (i < n - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        n_exp  = st ? 64 : 576;
        stored = (n < n_exp) ? n : n_exp;
        exp_q.delete();
        for (int i = 0; i < stored; i++) exp_q.push_back(model_word(fdata[i]));
        if (stored != n_exp) len_exp = 1'b1;
        if (n > n_exp) ovf_exp = 1'b1;
    endtask

    task automatic drain(input int pat, input int limit);
        int k = 0;
        int c = 0;
        int first = -1;
        int n = exp_q.size();
        bit held_v = 1'b0;
        logic [31:0] held = '0;
        while (k < limit && c < 4 * n + 40) begin
            case (pat)
                0:       oready = 1'b1;
                1:       oready = (c % 4 == 0) || (c % 4 == 3);
                default: oready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (ovalid && first < 0) begin
                first = c;
                chk("latency", 32'(first), 32'd2);
            end
            if (held_v) begin
                chk("hold_valid", 32'(ovalid), 32'd1);
                chk("hold_data", dout, held);
            end
            if (ovalid && oready) begin
                chk("data", dout, exp_q[k]);
                chk("olast", 32'(olast), 32'(k == n - 1));
                k++;
                held_v = 1'b0;
            end else if (ovalid) begin
                held_v = 1'b1;
                held   = dout;
            end else begin
                held_v = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        if (k < limit) chk("drain_timeout", 32'(k), 32'(limit));
        if (limit == n) begin
            chk("end_ovalid", 32'(ovalid), 32'd0);
            chk("end_busy", 32'(busy), 32'd0);
        end
        oready = 1'b0;
    endtask

    task automatic chk_errs();
        chk("len_err", 32'(len_err), 32'(len_exp));
        chk("ovf_err", 32'(ovf_err), 32'(ovf_exp));
    endtask

    initial begin
        rst    = 1'b1;
        state  = 1'b0;
        din    = '0;
        ivalid = 1'b0;
        idone  = 1'b0;
        oready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'd0);
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_olast", 32'(olast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_ovf_err", 32'(ovf_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full layer-1 frame, ramp through zero, downstream always ready
        for (int i = 0; i < 576; i++) fdata[i] = 32'(i - 288);
        feed(1'b0, 576, 0);
        drain(0, 576);
        chk_errs();

        // Layer-2 frame with input gaps, oready pattern 1,0,0,1
        for (int i = 0; i < 64; i++) fdata[i] = 32'(i * 3);
        feed(1'b1, 64, 2);
        drain(1, 64);
        chk_errs();

        // Random data and random backpressure
        for (int i = 0; i < 64; i++) fdata[i] = $urandom;
        feed(1'b1, 64, int'($urandom_range(0, 1)));
        drain(2, 64);
        chk_errs();

        // Short frame: idone on word 40
        for (int i = 0; i < 40; i++) fdata[i] = $urandom;
        feed(1'b1, 40, 0);
        drain(0, 40);
        chk_errs();

        // Overlong frame: words 65..70 dropped
        for (int i = 0; i < 70; i++) fdata[i] = $urandom;
        feed(1'b1, 70, 0);
        drain(2, 64);
        chk_errs();

        // Reset in the middle of a layer-1 drain
        for (int i = 0; i < 576; i++) fdata[i] = $urandom;
        feed(1'b0, 576, 0);
        drain(0, 10);
        rst = 1'b1;
        #1;
        chk("midrst_ovalid", 32'(ovalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_olast", 32'(olast), 32'd0);
        len_exp = 1'b0;
        ovf_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_errs();
        for (int i = 0; i < 64; i++) fdata[i] = $urandom;
        feed(1'b1, 64, 0);
        drain(2, 64);
        chk_errs();

        // Sign boundary values on a short frame
        fdata[0] = -32'sd5;
        fdata[1] = 32'd0;
        fdata[2] = 32'd7;
        feed(1'b1, 3, 0);
        drain(0, 3);
        chk_errs();

        // Single-word frame: idone accepted straight from IDLE
        fdata[0] = $urandom;
        feed(1'b0, 1, 0);
        drain(1, 1);
        chk_errs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
